sprite_evaluator: RTL and testbench
===================================

SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

Interface
REQ-001 Parameter OAMObjects, 64, number of OAM entries scanned (power of two, 2..256).
REQ-002 Parameter MaxSprites, 8, secondary-buffer slots per scanline (power of two, 2..16).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins evaluation of one scanline.
REQ-006 scanline  input  10  scanline to evaluate; sampled when start is accepted.
REQ-007 oam_addr  output  log2(OAMObjects)  OAM entry index being read.
REQ-008 oam_data  input  32  entry at oam_addr, one cycle read latency; layout [31] enable, [30] y-flip, [29] x-flip, [28] priority, [27:18] y, [17:8] x, [7:0] spriteref.
REQ-009 out_we  output  1  write strobe for one selected sprite.
REQ-010 out_slot  output  log2(MaxSprites)  secondary-buffer slot being written.
REQ-011 out_data  output  24  [23:16] spriteref, [15:6] x, [5:2] row, [1] priority, [0] x-flip.
REQ-012 busy  output  1  high from accepted start until done.
REQ-013 done  output  1  one-cycle pulse when evaluation ends.
REQ-014 sprite_count  output  log2(MaxSprites)+1  sprites written for this scanline; stable from done until next accepted start.
REQ-015 overflow  output  1  more than MaxSprites hits found; stable from done until next accepted start.

Function
REQ-016 FSM states IDLE, SCAN, DRAIN; IDLE->SCAN on start, SCAN->DRAIN after last address issued or MaxSprites-th hit, DRAIN->IDLE after the in-flight read resolves.
REQ-017 start accepted only in IDLE; start while busy ignored, no state change.
REQ-018 On accepted start (cycle 0): latch scanline, clear sprite_count and overflow, busy high from cycle 1.
REQ-019 oam_addr = i in cycle 1+i for i = 0..OAMObjects-1, one entry per cycle, strictly ascending.
REQ-020 Hit test on entry i in cycle 2+i: enable=1 and diff = (scanline - y) mod 1024 < 16; 10-bit wrap-around, so y=1020 hits scanlines 1020..1023 and 0..11.
REQ-021 row = diff[3:0] when y-flip=0, 15 - diff[3:0] when y-flip=1.
REQ-022 Hit on entry i: out_we high in cycle 3+i, out_slot = prior sprite_count, out_data per REQ-011; sprite_count increments in the same cycle.
REQ-023 Hits are written in ascending OAM index order, slots contiguous from 0; non-hits produce no write.
REQ-024 out_we, out_slot, out_data are registered; out_slot and out_data hold their last values when out_we=0.
REQ-025 No hits: done pulses in cycle OAMObjects+3, sprite_count=0, overflow=0.
REQ-026 done pulses one cycle after the final write or final compare, then busy drops the same cycle; start accepted again the cycle after done.

Reset
REQ-027 While reset is high: state IDLE, oam_addr=0, out_we=0, out_slot=0, out_data=0, busy=0, done=0, sprite_count=0, overflow=0.
REQ-028 Reset during SCAN or DRAIN aborts evaluation immediately; no further out_we or done for that scanline.

Configuration
REQ-029 Macro SPRITE_OVERFLOW_EN defined: after MaxSprites writes, scanning continues through all entries without further writes; first additional hit sets overflow=1; done in cycle OAMObjects+3.
REQ-030 Macro SPRITE_OVERFLOW_EN undefined: scanning stops after the MaxSprites-th write, in-flight read discarded, done the following cycle; overflow tied to 0.

Verification
REQ-031 All entries enable=0, start with scanline=100 -> no out_we, done in cycle 67, sprite_count=0, overflow=0.
REQ-032 Entry 5 {en=1, y=96, x=200, ref=0x3A, yflip=0}, scanline=100 -> single out_we in cycle 8, out_slot=0, out_data={0x3A, 200, row 4, 0, 0}, sprite_count=1.
REQ-033 Entry 0 {en=1, y=1020, yflip=1}, scanline=3 -> out_we in cycle 3, row = 15-7 = 8.
REQ-034 Entries 0..9 all hitting scanline 50 -> slots 0..7 hold entries 0..7; with SPRITE_OVERFLOW_EN overflow=1 and done in cycle 67; without it overflow=0 and done in cycle 11.
REQ-035 Assert reset in cycle 20 of a scan, release, then start with scanline=200 -> no out_we or done before new start; new scan follows REQ-019 timing from cycle 0.
REQ-036 Pulse start in cycle 10 of a busy scan -> ignored; results identical to an undisturbed scan.

Source files
------------

// File: rtl/sprite_evaluator.sv
// Per-scanline sprite evaluator: walks OAM in index order and writes up to MaxSprites hits
// into a secondary buffer. Optional macro SPRITE_OVERFLOW_EN keeps scanning past a full buffer and flags overflow.
module sprite_evaluator #(
  parameter int OAMObjects = 64,
  parameter int MaxSprites = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [9:0]                    scanline,
  output logic [$clog2(OAMObjects)-1:0] oam_addr,
  input  logic [31:0]                   oam_data,
  output logic                          out_we,
  output logic [$clog2(MaxSprites)-1:0] out_slot,
  output logic [23:0]                   out_data,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(MaxSprites):0]   sprite_count,
  output logic                          overflow,
  output logic [1:0]                    dbg_state
);

  localparam int AW = $clog2(OAMObjects);
  localparam int SW = $clog2(MaxSprites);
  localparam logic [AW-1:0] ADDR_LAST = AW'(OAMObjects - 1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [SW:0]   CNT_MAX   = (SW+1)'(MaxSprites);
  localparam logic [SW:0]   CNT_LAST  = (SW+1)'(MaxSprites - 1);
  localparam logic [SW:0]   CNT_ONE   = (SW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [9:0] scan_q;
  logic       cmp_v;
  logic [9:0] diff;
  logic [3:0] row;
  logic       accept, last_addr, hit, full, wr, stop_early;

  // start is a single-cycle request with no ready; it is taken only in IDLE outside the done cycle,
  // otherwise it is dropped without any state change.
  assign accept    = (state == IDLE) && start && !done;
  assign last_addr = (oam_addr == ADDR_LAST);

  // cmp_v marks cycles where oam_data belongs to an address issued during SCAN.
  assign diff = scan_q - oam_data[27:18];
  assign hit  = cmp_v && oam_data[31] && (diff[9:4] == 6'd0);
  assign full = (sprite_count == CNT_MAX);
  assign wr   = hit && !full;
  assign row  = oam_data[30] ? ~diff[3:0] : diff[3:0];

`ifdef SPRITE_OVERFLOW_EN
  assign stop_early = 1'b0;
`else
  assign stop_early = wr && (sprite_count == CNT_LAST);
`endif

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SCAN;
      SCAN:    if (stop_early || last_addr) state_n = DRAIN;
      DRAIN:   if (!cmp_v) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_q       <= '0;
      oam_addr     <= '0;
      cmp_v        <= 1'b0;
      out_we       <= 1'b0;
      out_slot     <= '0;
      out_data     <= '0;
      done         <= 1'b0;
      sprite_count <= '0;
    end else begin
      done   <= (state == DRAIN) && (state_n == IDLE);
      // A full buffer in the non-overflow build discards the read already in flight.
      cmp_v  <= (state == SCAN) && !stop_early;
      out_we <= wr;
      if (accept) begin
        scan_q       <= scanline;
        oam_addr     <= '0;
        sprite_count <= '0;
      end else if ((state == SCAN) && !last_addr) begin
        oam_addr <= oam_addr + ADDR_ONE;
      end
      if (wr) begin
        out_slot     <= sprite_count[SW-1:0];
        out_data     <= {oam_data[7:0], oam_data[17:8], row, oam_data[28], oam_data[29]};
        sprite_count <= sprite_count + CNT_ONE;
      end
    end
  end

`ifdef SPRITE_OVERFLOW_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (accept) begin
      overflow <= 1'b0;
    end else if (hit && full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed bench for sprite_evaluator: an OAM-walking reference model predicts every write,
// the done cycle, busy, counts and overflow; literal checks pin the model on hand-worked cases.
module tb_sprite_evaluator;

  localparam int N   = 64;
  localparam int MAX = 8;
  localparam int AW  = 6;
  localparam int SW  = 3;
  localparam int NO_OVF = 1000000;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [9:0]    scanline;
  logic [AW-1:0] oam_addr;
  logic [31:0]   oam_data;
  logic          out_we;
  logic [SW-1:0] out_slot;
  logic [23:0]   out_data;
  logic          busy;
  logic          done;
  logic [SW:0]   sprite_count;
  logic          overflow;
  logic [1:0]    dbg_state;

  logic [31:0]   oam [N];

  sprite_evaluator #(.OAMObjects(N), .MaxSprites(MAX)) dut (
    .clk(clk), .reset(reset), .start(start), .scanline(scanline),
    .oam_addr(oam_addr), .oam_data(oam_data),
    .out_we(out_we), .out_slot(out_slot), .out_data(out_data),
    .busy(busy), .done(done), .sprite_count(sprite_count),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // clock / OAM memory with one-cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) oam_data <= oam[oam_addr];

  // scoreboard: {write cycle[47:32], slot[31:24], data[23:0]}
  logic [47:0]   exp_q[$];
  int            exp_done, exp_cnt, exp_ovf_cyc;
  int            total, bad;
  int            held_cnt;
  logic          held_ovf;
  logic [SW-1:0] last_slot;
  logic [23:0]   last_data;
  int            first_we_cyc, obs_done_cyc;
  logic [SW-1:0] first_slot;
  logic [23:0]   first_data;

  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  function automatic logic [31:0] ent(input logic en, input logic yf, input logic xf,
                                      input logic pr, input int y, input int x, input int r);
    return {en, yf, xf, pr, 10'(y), 10'(x), 8'(r)};
  endfunction

  task automatic clear_oam();
    for (int i = 0; i < N; i++) oam[i] = 32'h0;
  endtask

  // reference model: walk OAM, apply the wrap-around hit rule, schedule writes at 3+i
  function automatic void build_model(input int sl);
    int n, diff, row;
    logic [31:0] e;
    exp_q.delete();
    n = 0;
    exp_done = N + 3;
    exp_ovf_cyc = NO_OVF;
    for (int i = 0; i < N; i++) begin
      e = oam[i];
      diff = (sl - int'(e[27:18]) + 1024) % 1024;
      if (e[31] && diff < 16) begin
        if (n < MAX) begin
          row = e[30] ? 15 - diff : diff;
          exp_q.push_back({16'(3 + i), 8'(n), e[7:0], e[17:8], 4'(row), e[28], e[29]});
          n++;
`ifndef SPRITE_OVERFLOW_EN
          if (n == MAX) begin
            exp_done = 4 + i;
            break;
          end
`endif
        end else if (exp_ovf_cyc > 3 + i) begin
          exp_ovf_cyc = 3 + i;
        end
      end
    end
    exp_cnt = n;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_oam_addr"}, oam_addr, 0);
    chk({tag, "_out_we"}, out_we, 0);
    chk({tag, "_out_slot"}, out_slot, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, sprite_count, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // driver + per-cycle compare; poke_at >= 1 pulses a stray start (with a different scanline)
  task automatic run_scan(input int sl, input int poke_at);
    int nw;
    bit seen_done;
    logic [47:0] e;
    build_model(sl);
    nw = 0;
    seen_done = 0;
    first_we_cyc = -1;
    obs_done_cyc = -1;
    @(negedge clk);
    chk("held_count", sprite_count, held_cnt);
    chk("held_overflow", overflow, held_ovf);
    start = 1'b1;
    scanline = 10'(sl);
    for (int t = 1; t <= 200 && !seen_done; t++) begin
      @(negedge clk);
      if (out_we) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_write: cycle %0d slot %0d data %0h, no write expected", t, out_slot, out_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_cycle", t, e[47:32]);
          chk("write_slot", out_slot, e[31:24]);
          chk("write_data", out_data, e[23:0]);
          last_slot = e[24 +: SW];
          last_data = e[23:0];
          nw++;
          if (first_we_cyc < 0) begin
            first_we_cyc = t;
            first_slot = out_slot;
            first_data = out_data;
          end
        end
      end else begin
        chk("hold_slot", out_slot, last_slot);
        chk("hold_data", out_data, last_data);
      end
      chk("busy", busy, t < exp_done);
      chk("count", sprite_count, nw);
      chk("overflow", overflow, t >= exp_ovf_cyc);
      if (t <= N && t <= exp_done - 2) chk("oam_addr", oam_addr, t - 1);
      if (done) begin
        seen_done = 1;
        obs_done_cyc = t;
        chk("done_cycle", t, exp_done);
        chk("final_count", sprite_count, exp_cnt);
        chk("missing_writes", exp_q.size(), 0);
      end
      start = (t == poke_at);
      if (t == poke_at) scanline = 10'(sl + 37);
    end
    start = 1'b0;
    if (!seen_done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: no done within 200 cycles, expected cycle %0d", exp_done);
    end
    held_cnt = exp_cnt;
    held_ovf = (exp_ovf_cyc != NO_OVF);
  endtask

  // reset asserted in cycle 20 of a scan; nothing may follow until a new start
  task automatic abort_run(input int sl);
    @(negedge clk);
    start = 1'b1;
    scanline = 10'(sl);
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("abort_no_we", out_we, 0);
      chk("abort_no_done", done, 0);
      chk("abort_busy", busy, 0);
      if (t == 2) reset = 1'b0;
    end
    last_slot = '0;
    last_data = '0;
    held_cnt = 0;
    held_ovf = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b1;
    start = 1'b0;
    scanline = '0;
    held_cnt = 0;
    held_ovf = 1'b0;
    last_slot = '0;
    last_data = '0;
    clear_oam();
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;

    // all entries disabled
    run_scan(100, -1);
    chk("t1_done_lit", obs_done_cyc, 67);
    chk("t1_no_write_lit", first_we_cyc, -1);

    // single hit on entry 5
    oam[5] = ent(1, 0, 0, 0, 96, 200, 'h3A);
    run_scan(100, -1);
    chk("t2_we_cycle_lit", first_we_cyc, 8);
    chk("t2_slot_lit", first_slot, 0);
    chk("t2_data_lit", first_data, {8'h3A, 10'd200, 4'd4, 1'b0, 1'b0});
    chk("t2_count_lit", sprite_count, 1);

    // y wraps past 1023, y-flipped
    clear_oam();
    oam[0] = ent(1, 1, 0, 0, 1020, 17, 'h55);
    run_scan(3, -1);
    chk("t3_we_cycle_lit", first_we_cyc, 3);
    chk("t3_row_lit", first_data[5:2], 4'd8);

    // ten hits against eight slots
    clear_oam();
    for (int i = 0; i < 10; i++)
      oam[i] = ent(1, 1'(i % 2), 1'((i / 2) % 2), (i % 3) == 0, 40 + i, 16 * i + 3, 'h80 + i);
    run_scan(50, -1);
    chk("t4_count_lit", sprite_count, 8);
`ifdef SPRITE_OVERFLOW_EN
    chk("t4_done_lit", obs_done_cyc, 67);
    chk("t4_ovf_lit", overflow, 1);
`else
    chk("t4_done_lit", obs_done_cyc, 11);
    chk("t4_ovf_lit", overflow, 0);
`endif

    // boundaries: diff 15 hits, diff 16 misses, disabled entry, last entry hit
    clear_oam();
    oam[3]  = ent(1, 0, 0, 0, 200, 5, 'h11);
    oam[10] = ent(1, 0, 0, 0, 199, 6, 'h22);
    oam[20] = ent(0, 0, 0, 0, 210, 7, 'h33);
    oam[40] = ent(1, 1, 1, 1, 205, 1023, 'h44);
    oam[63] = ent(1, 0, 1, 0, 215, 0, 'hFF);
    run_scan(215, -1);
    chk("t5_we_cycle_lit", first_we_cyc, 6);
    chk("t5_data_lit", first_data, {8'h11, 10'd5, 4'd15, 1'b0, 1'b0});
    chk("t5_count_lit", sprite_count, 3);

    // same scan with a stray start in cycle 10
    run_scan(215, 10);

    // reset mid-scan, then a fresh scan at 200
    abort_run(215);
    run_scan(200, -1);
    chk("t7_count_lit", sprite_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
